run_length_meter: RTL and testbench

//   Downstream consumer of the glitch filter: samples the filtered, debounced

---
 rtl/run_length_meter_if.sv | 10 +
 rtl/run_length_meter.sv | 52 +++++
 tb/tb_run_length_meter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/run_length_meter_if.sv
// run_length_meter_if: record stream from the meter to a downstream sink
`timescale 1ns/1ps
interface run_length_meter_if #(parameter int CNT_W = 8);
  logic out_valid;
  logic out_ready;
  logic out_level;
  logic [CNT_W-1:0] out_len;
  modport master (output out_valid, out_level, out_len, input out_ready);
  modport slave (input out_valid, out_level, out_len, output out_ready);
endinterface

// File: rtl/run_length_meter.sv
// run_length_meter: measures held-level durations and queues {level, length} records in a FWFT FIFO
`timescale 1ns/1ps
module run_length_meter #(
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic sig_in,
  run_length_meter_if.master o,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic overflow
);
  localparam int AW = $clog2(DEPTH);
  logic sig_q, armed, sig_edge, push, pop, full, empty, wr_en;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CNT_W:0] mem [DEPTH];
  always_comb begin
    sig_edge = sig_in != sig_q;
    push = sig_edge && armed;
    empty = fifo_count == '0;
    full = fifo_count == (AW+1)'(DEPTH);
    pop = !empty && o.out_ready;
    // a pop frees a slot in the same edge, so a full FIFO still accepts
    wr_en = push && (!full || pop);
    o.out_valid = !empty;
    o.out_level = empty ? 1'b0 : mem[rd_ptr][CNT_W];
    o.out_len = empty ? '0 : mem[rd_ptr][CNT_W-1:0];
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sig_q <= 1'b0;
      cnt <= '0;
      armed <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      overflow <= 1'b0;
    end else begin
      sig_q <= sig_in;
      cnt <= sig_edge ? CNT_W'(1) : (&cnt ? cnt : cnt + CNT_W'(1));
      armed <= armed | sig_edge;
      wr_ptr <= wr_en ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      fifo_count <= fifo_count + (AW+1)'(wr_en) - (AW+1)'(pop);
      overflow <= overflow | (push && !wr_en);
    end
  end
  always_ff @(posedge clock)
    if (wr_en) mem[wr_ptr] <= {sig_q, cnt};
endmodule

// File: tb/tb_run_length_meter.sv
// tb_run_length_meter: directed checks of run measurement, saturation, FIFO full/overflow and reset
`timescale 1ns/1ps
module tb_run_length_meter;
  localparam int CNT_W = 4;
  localparam int DEPTH = 4;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic sig_in = 1'b0;
  logic overflow;
  logic [$clog2(DEPTH):0] fifo_count;
  int checks = 0;
  int errors = 0;
  run_length_meter_if #(.CNT_W(CNT_W)) bus ();
  run_length_meter #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .sig_in(sig_in), .o(bus.master),
    .fifo_count(fifo_count), .overflow(overflow)
  );
  always #5 clock = ~clock;
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "time limit");
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic head(input string tag, input logic lvl, input int len);
    chk({tag, "_valid"}, 32'(bus.out_valid), 1);
    chk({tag, "_level"}, 32'(bus.out_level), 32'(lvl));
    chk({tag, "_len"}, 32'(bus.out_len), 32'(len));
  endtask
  task automatic pop1();
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
  endtask
  task automatic rst_pulse();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask
  initial begin
    bus.out_ready = 1'b0;
    repeat (4) begin
      sig_in = 1'($urandom);
      bus.out_ready = 1'($urandom);
      tick(1);
    end
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_level", 32'(bus.out_level), 0);
    chk("rst_len", 32'(bus.out_len), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    sig_in = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    // basic run: the leading 0-run is unarmed and must not appear
    tick(3);
    sig_in = 1'b1;
    tick(5);
    chk("basic_unarmed_count", 32'(fifo_count), 0);
    sig_in = 1'b0;
    tick(1);
    head("basic", 1'b1, 5);
    chk("basic_count", 32'(fifo_count), 1);
    pop1();
    chk("basic_popped_valid", 32'(bus.out_valid), 0);
    chk("basic_popped_count", 32'(fifo_count), 0);
    // saturation: 0-run of 2 is pushed, then a 20-edge 1-run clamps to 15
    sig_in = 1'b1;
    tick(20);
    head("sat_prev", 1'b0, 2);
    sig_in = 1'b0;
    tick(1);
    chk("sat_count", 32'(fifo_count), 2);
    pop1();
    head("sat", 1'b1, 15);
    pop1();
    chk("sat_empty", 32'(bus.out_valid), 0);
    // overflow: six length-2 runs into a 4-deep FIFO
    rst_pulse();
    sig_in = 1'b1;
    tick(2);
    for (int i = 0; i < 6; i++) begin
      sig_in = ~sig_in;
      tick(2);
    end
    chk("ovf_count", 32'(fifo_count), 4);
    chk("ovf_flag", 32'(overflow), 1);
    for (int i = 0; i < 4; i++) begin
      head($sformatf("ovf_drain%0d", i), 1'(~i[0]), 2);
      pop1();
    end
    chk("ovf_drained", 32'(bus.out_valid), 0);
    chk("ovf_sticky", 32'(overflow), 1);
    // full FIFO with simultaneous push and pop
    rst_pulse();
    sig_in = 1'b1;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      sig_in = ~sig_in;
      tick(2);
    end
    chk("full_count", 32'(fifo_count), 4);
    head("full_head", 1'b1, 2);
    sig_in = 1'b0;
    pop1();
    chk("pp_count", 32'(fifo_count), 4);
    chk("pp_ovf", 32'(overflow), 0);
    head("pp_hold", 1'b0, 2);
    tick(1);
    head("pp_stable", 1'b0, 2);
    for (int i = 0; i < 4; i++) begin
      head($sformatf("pp_drain%0d", i), 1'(i[0]), 2);
      pop1();
    end
    chk("pp_empty", 32'(fifo_count), 0);
    // reset mid-run with two records queued
    sig_in = 1'b1;
    tick(2);
    sig_in = 1'b0;
    tick(3);
    chk("mid_count", 32'(fifo_count), 2);
    reset = 1'b0;
    #1;
    chk("mid_valid", 32'(bus.out_valid), 0);
    chk("mid_level", 32'(bus.out_level), 0);
    chk("mid_len", 32'(bus.out_len), 0);
    chk("mid_cnt0", 32'(fifo_count), 0);
    chk("mid_ovf", 32'(overflow), 0);
    reset = 1'b1;
    tick(2);
    sig_in = 1'b1;
    tick(1);
    chk("post_unarmed", 32'(fifo_count), 0);
    tick(2);
    sig_in = 1'b0;
    tick(1);
    head("post_first", 1'b1, 3);
    chk("post_count", 32'(fifo_count), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
